// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: requester and adder-side bundle of the shared adder arbiter.
// master = requester/adder side, slave = arbiter.
interface adder_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] a0_in1;
  logic [31:0] a0_in2;
  logic [31:0] a1_in1;
  logic [31:0] a1_in2;
  logic        sub0;
  logic        sub1;
  logic        done0;
  logic        done1;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [1:0]  gnt;
  logic        busy;
  logic        add_en;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic [35:0] add_out;

  modport master (
    output req0, req1,
    output a0_in1, a0_in2, a1_in1, a1_in2,
    output sub0, sub1,
    input  done0, done1, result, flags, gnt, busy,
    input  add_en, add_in1, add_in2,
    output add_out
  );

  modport slave (
    input  req0, req1,
    input  a0_in1, a0_in2, a1_in1, a1_in2,
    input  sub0, sub1,
    output done0, done1, result, flags, gnt, busy,
    output add_en, add_in1, add_in2,
    input  add_out
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 32-bit adder by two requesters.
// ADDER_ARB_SUB_EN enables in1-in2 via two's-complement of operand 2.
module adder_arbiter #(
  parameter bit          RR_INIT     = 1'b0,
  parameter int unsigned HOLD_CYCLES = 0
) (
  input logic            clk,
  input logic            clr,
  adder_arbiter_if.slave bus
);

  localparam logic [3:0] LP_HOLD = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [1:0]  r_gnt;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
`ifdef ADDER_ARB_SUB_EN
  logic        r_sub;
`endif

  logic        w_req;
  logic        w_pick1;
  logic        w_cnt_zero;
  logic        w_issue;
  logic        w_resp;
  logic [31:0] w_op2;

  // Arbitration: a lone requester wins; on contention the one not last served
  always_comb begin
    w_req      = bus.req0 | bus.req1;
    w_pick1    = bus.req1 & (~bus.req0 | ~r_last);
    w_cnt_zero = (r_cnt == 4'd0);
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_next = S_ISSUE;
      S_ISSUE: if (w_cnt_zero) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Grant, operand latch, hold countdown, result capture, pointer update
  always_ff @(posedge clk) begin
    if (clr) begin
      r_last   <= ~RR_INIT;
      r_cnt    <= 4'd0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_gnt    <= 2'b00;
      r_result <= '0;
      r_flags  <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_gnt <= w_pick1 ? 2'b10 : 2'b01;
            r_op1 <= w_pick1 ? bus.a1_in1 : bus.a0_in1;
            r_op2 <= w_pick1 ? bus.a1_in2 : bus.a0_in2;
            r_cnt <= LP_HOLD;
          end
        end
        S_ISSUE: begin
          if (w_cnt_zero) begin
            r_result <= bus.add_out[31:0];
            r_flags  <= bus.add_out[35:32];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_last <= r_gnt[1];
          r_gnt  <= 2'b00;
        end
        default: r_gnt <= 2'b00;
      endcase
    end
  end

`ifdef ADDER_ARB_SUB_EN
  // Subtract bit of the granted requester, frozen for the operation
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sub <= 1'b0;
    end else if (r_state == S_IDLE && w_req) begin
      r_sub <= w_pick1 ? bus.sub1 : bus.sub0;
    end
  end
`endif

  // Adder drive (zero outside ISSUE) and requester responses
  always_comb begin
    w_issue = (r_state == S_ISSUE);
    w_resp  = (r_state == S_RESP);
`ifdef ADDER_ARB_SUB_EN
    w_op2   = r_sub ? (~r_op2 + 32'd1) : r_op2;
`else
    w_op2   = r_op2;
`endif
    bus.add_en  = w_issue;
    bus.add_in1 = w_issue ? r_op1 : '0;
    bus.add_in2 = w_issue ? w_op2 : '0;
    bus.done0   = w_resp & r_gnt[0];
    bus.done1   = w_resp & r_gnt[1];
    bus.gnt     = r_gnt;
    bus.busy    = (r_state != S_IDLE);
    bus.result  = r_result;
    bus.flags   = r_flags;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: randomized and directed bench for adder_arbiter.
// Two instances: HOLD_CYCLES=0/RR_INIT=0 and HOLD_CYCLES=2/RR_INIT=1.
module tb_adder_arbiter;

  logic clk = 1'b0;
  logic clr0;
  logic clr2;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   m_last;

  always #5 clk = ~clk;

  adder_arbiter_if u_if0 ();
  adder_arbiter_if u_if2 ();

  adder_arbiter #(.RR_INIT(1'b0), .HOLD_CYCLES(0)) u_dut0 (
    .clk (clk),
    .clr (clr0),
    .bus (u_if0)
  );

  adder_arbiter #(.RR_INIT(1'b1), .HOLD_CYCLES(2)) u_dut2 (
    .clk (clk),
    .clr (clr2),
    .bus (u_if2)
  );

  // Adder environment: flags derived bitwise from the carry chain
  function automatic logic [35:0] adder_fn(logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[31], s[31:0] == 32'd0, s[32],
            (a[31] == b[31]) && (s[31] != a[31]), s[31:0]};
  endfunction

  always_comb u_if0.add_out = u_if0.add_en ? adder_fn(u_if0.add_in1, u_if0.add_in2) : '0;
  always_comb u_if2.add_out = u_if2.add_en ? adder_fn(u_if2.add_in1, u_if2.add_in2) : '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: operand seen by the adder
  function automatic logic [31:0] ref_in2(logic [31:0] b, bit s);
    logic [31:0] neg;
    neg = 32'd0 - b;
`ifdef ADDER_ARB_SUB_EN
    return s ? neg : b;
`else
    return (s && neg == 32'd0) ? b : b;
`endif
  endfunction

  // Reference: {N,Z,C,V,sum} from integer arithmetic
  function automatic logic [35:0] ref_out(logic [31:0] a, logic [31:0] b);
    longint      us;
    longint      ss;
    logic [31:0] s32;
    bit          c;
    bit          v;
    us  = longint'(a) + longint'(b);
    ss  = longint'($signed(a)) + longint'($signed(b));
    s32 = us[31:0];
    c   = us > 64'sh0_FFFF_FFFF;
    v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {s32[31], s32 == 32'd0, c, v, s32};
  endfunction

  function automatic logic [31:0] rnd32();
    unique case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One or two requests on instance 0, checked cycle by cycle
  task automatic txn(input bit q0, input bit q1,
                     input logic [31:0] x0a, input logic [31:0] x0b,
                     input logic [31:0] x1a, input logic [31:0] x1b,
                     input bit s0, input bit s1);
    int          order[2];
    int          nops;
    logic [31:0] opa[2];
    logic [31:0] opb[2];
    bit          sb[2];
    opa[0] = x0a; opb[0] = x0b; sb[0] = s0;
    opa[1] = x1a; opb[1] = x1b; sb[1] = s1;
    if (q0 && q1) begin
      order[0] = m_last ? 0 : 1;
      order[1] = 1 - order[0];
      nops = 2;
    end else begin
      order[0] = q1 ? 1 : 0;
      order[1] = 0;
      nops = 1;
    end
    u_if0.req0 = q0; u_if0.req1 = q1;
    u_if0.a0_in1 = x0a; u_if0.a0_in2 = x0b; u_if0.sub0 = s0;
    u_if0.a1_in1 = x1a; u_if0.a1_in2 = x1b; u_if0.sub1 = s1;
    for (int t = 1; t <= 3 * nops; t++) begin
      int          k;
      int          ph;
      int          g;
      logic [31:0] e2;
      logic [35:0] eo;
      @(posedge clk); #1;
      k  = (t - 1) / 3;
      ph = (t - 1) % 3;
      g  = order[k];
      e2 = ref_in2(opb[g], sb[g]);
      eo = ref_out(opa[g], e2);
      if (ph == 0) begin
        check("issue_gnt", 64'(u_if0.gnt), 64'(1 << g));
        check("issue_busy", 64'(u_if0.busy), 64'd1);
        check("issue_en", 64'(u_if0.add_en), 64'd1);
        check("issue_in1", 64'(u_if0.add_in1), 64'(opa[g]));
        check("issue_in2", 64'(u_if0.add_in2), 64'(e2));
        check("issue_done", 64'({u_if0.done1, u_if0.done0}), 64'd0);
        if (g == 0) begin
          u_if0.a0_in1 = $urandom; u_if0.a0_in2 = $urandom;
          u_if0.sub0 = 1'($urandom);
        end else begin
          u_if0.a1_in1 = $urandom; u_if0.a1_in2 = $urandom;
          u_if0.sub1 = 1'($urandom);
        end
      end else if (ph == 1) begin
        check("resp_done", 64'({u_if0.done1, u_if0.done0}), 64'(1 << g));
        check("resp_result", 64'(u_if0.result), 64'(eo[31:0]));
        check("resp_flags", 64'(u_if0.flags), 64'(eo[35:32]));
        check("resp_en", 64'(u_if0.add_en), 64'd0);
        check("resp_gnt", 64'(u_if0.gnt), 64'(1 << g));
        if (g == 0) u_if0.req0 = 1'b0;
        else        u_if0.req1 = 1'b0;
        m_last = (g == 1);
      end else begin
        check("idle_state", 64'({u_if0.gnt, u_if0.busy, u_if0.add_en}), 64'd0);
        check("idle_bus", 64'({u_if0.add_in1, u_if0.add_in2}), 64'd0);
        check("idle_done", 64'({u_if0.done1, u_if0.done0}), 64'd0);
      end
    end
  endtask

  task automatic chk_zero2(string tag);
    check({tag, "_ctl"}, 64'({u_if2.gnt, u_if2.busy, u_if2.add_en,
                              u_if2.done1, u_if2.done0}), 64'd0);
    check({tag, "_bus"}, 64'({u_if2.add_in1, u_if2.add_in2}), 64'd0);
    check({tag, "_res"}, 64'({u_if2.result, u_if2.flags}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_done;
    clr0 = 1'b1; clr2 = 1'b1;
    u_if0.req0 = 0; u_if0.req1 = 0; u_if0.sub0 = 0; u_if0.sub1 = 0;
    u_if0.a0_in1 = 0; u_if0.a0_in2 = 0; u_if0.a1_in1 = 0; u_if0.a1_in2 = 0;
    u_if2.req0 = 0; u_if2.req1 = 0; u_if2.sub0 = 0; u_if2.sub1 = 0;
    u_if2.a0_in1 = 0; u_if2.a0_in2 = 0; u_if2.a1_in1 = 0; u_if2.a1_in2 = 0;
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst0_ctl", 64'({u_if0.gnt, u_if0.busy, u_if0.add_en,
                           u_if0.done1, u_if0.done0}), 64'd0);
    check("rst0_bus", 64'({u_if0.add_in1, u_if0.add_in2}), 64'd0);
    check("rst0_res", 64'({u_if0.result, u_if0.flags}), 64'd0);
    chk_zero2("rst2");
    clr0 = 1'b0; clr2 = 1'b0;

    txn(1, 0, 32'h3, 32'h4, 0, 0, 0, 0);
    check("tp_add_res", 64'(u_if0.result), 64'h7);
    check("tp_add_flg", 64'(u_if0.flags), 64'h0);
    txn(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h1, 0, 0);
    check("tp_zc_res", 64'(u_if0.result), 64'h0);
    check("tp_zc_flg", 64'(u_if0.flags), 64'h6);
    txn(0, 1, 0, 0, 32'h7FFF_FFFF, 32'h1, 0, 0);
    check("tp_nv_res", 64'(u_if0.result), 64'h8000_0000);
    check("tp_nv_flg", 64'(u_if0.flags), 64'h9);
    txn(1, 1, 32'h10, 32'h20, 32'h100, 32'h200, 0, 0);
    txn(1, 1, 32'h11, 32'h22, 32'h111, 32'h222, 0, 0);
    txn(1, 0, 32'h5, 32'h7, 0, 0, 1, 0);
`ifdef ADDER_ARB_SUB_EN
    check("tp_sub_res", 64'(u_if0.result), 64'hFFFF_FFFE);
    check("tp_sub_flg", 64'(u_if0.flags), 64'h8);
`else
    check("tp_sub_res", 64'(u_if0.result), 64'hC);
    check("tp_sub_flg", 64'(u_if0.flags), 64'h0);
`endif

    // A request withdrawn before any edge samples it is not served
    u_if0.req0 = 1'b1;
    #3;
    u_if0.req0 = 1'b0;
    @(posedge clk); #1;
    check("withdrawn", 64'({u_if0.busy, u_if0.gnt}), 64'd0);

    for (int i = 0; i < 40; i++) begin
      int p;
      p = $urandom_range(1, 3);
      txn(p[0], p[1], rnd32(), rnd32(), rnd32(), rnd32(),
          1'($urandom), 1'($urandom));
    end

    // Instance 2: contention right after reset favours requester 1
    u_if2.req0 = 1'b1; u_if2.req1 = 1'b1;
    @(posedge clk); #1;
    check("rr_init_gnt", 64'(u_if2.gnt), 64'h2);
    clr2 = 1'b1; u_if2.req0 = 1'b0; u_if2.req1 = 1'b0;
    @(posedge clk); #1;
    clr2 = 1'b0;
    chk_zero2("clr_issue1");

    // Hold of 2: three ISSUE cycles, then done0
    u_if2.req0 = 1'b1; u_if2.a0_in1 = 32'd10; u_if2.a0_in2 = 32'd20;
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); #1;
      if (t <= 3) begin
        check("hold_en", 64'({u_if2.add_en, u_if2.busy, u_if2.gnt}), 64'b1101);
        check("hold_in1", 64'(u_if2.add_in1), 64'd10);
        check("hold_done", 64'(u_if2.done0), 64'd0);
        u_if2.a0_in1 = $urandom;
      end else if (t == 4) begin
        check("hold_done4", 64'({u_if2.done1, u_if2.done0}), 64'b01);
        check("hold_res", 64'(u_if2.result), 64'd30);
        check("hold_en4", 64'(u_if2.add_en), 64'd0);
        u_if2.req0 = 1'b0;
      end else begin
        check("hold_idle", 64'({u_if2.busy, u_if2.gnt}), 64'd0);
      end
    end

    // clr during the 2nd ISSUE cycle aborts without a done
    u_if2.req0 = 1'b1; u_if2.a0_in1 = 32'd1; u_if2.a0_in2 = 32'd2;
    @(posedge clk); #1;
    check("abort_en1", 64'(u_if2.add_en), 64'd1);
    @(posedge clk); #1;
    check("abort_en2", 64'(u_if2.add_en), 64'd1);
    clr2 = 1'b1; u_if2.req0 = 1'b0;
    @(posedge clk); #1;
    clr2 = 1'b0;
    chk_zero2("abort");
    seen_done = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      if (u_if2.done0 || u_if2.done1) seen_done = 1'b1;
    end
    check("abort_nodone", 64'(seen_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
